multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ENABLE_ADDI, 1, 1 = opcode 001000 decoded as ADDI; 0 = treated as illegal
REQ-002 Ports, one per line (name  direction  width  meaning):
  CLK  input  1  sole clock, rising edge
  RST  input  1  synchronous reset, active-high
  OP  input  6  instruction opcode, IR[31:26]
  MEM_READY  input  1  memory handshake, access completes this cycle
  PCWrite  output  1  unconditional PC load
  PCWriteCond  output  1  PC load if ALU Zero
  IorD  output  1  0 = PC address, 1 = ALUOut address
  MemRead  output  1  memory read request
  MemWrite  output  1  memory write request
  IRWrite  output  1  instruction register load
  MemtoReg  output  1  1 = write-back from MDR
  RegDst  output  1  1 = rd, 0 = rt
  RegWrite  output  1  register file write
  ALUSrcA  output  1  0 = PC, 1 = A
  ALUSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
  ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
  PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target
  ILLEGAL  output  1  one-cycle pulse on undecodable opcode
  STATE  output  4  current state encoding, for debug and verification
REQ-003 Clock and reset are decided: one clock; reset is synchronous and active-high.

Function
REQ-004 Module SHALL be a single FSM; state register updates only on the rising edge of CLK.
REQ-005 States SHALL be encoded FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-006 Outputs not listed for a state SHALL be 0 in that state.
REQ-007 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite = MEM_READY.
  - Stays in FETCH while MEM_READY=0; goes to DECODE when MEM_READY=1.
REQ-008 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, then branch on OP:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 with ENABLE_ADDI=1 -> ADDIEX
  - any other opcode -> FETCH, with ILLEGAL=1 during that DECODE cycle only
REQ-009 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD if OP=100011, else MEMWR.
REQ-010 MEMRD SHALL drive MemRead=1, IorD=1; it holds until MEM_READY=1, then goes to MEMWB.
REQ-011 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-012 MEMWR SHALL drive MemWrite=1, IorD=1; it holds until MEM_READY=1, then goes to FETCH.
REQ-013 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-014 ALUWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-015 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-016 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
REQ-017 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-018 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-019 OP SHALL be sampled only in DECODE and MEMADR; changes to OP in other states SHALL have no effect.
REQ-020 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite and PCWrite SHALL never be 1 in the same cycle.
REQ-021 With zero wait states, instruction latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each cycle of MEM_READY=0 in FETCH, MEMRD or MEMWR adds one cycle.

Reset
REQ-022 RST=1 at a rising edge SHALL force STATE=FETCH regardless of current state, including mid-wait in MEMRD or MEMWR.
REQ-023 While RST=1, all outputs other than STATE SHALL be 0, ILLEGAL included.
  - FETCH strobes are suppressed; normal FETCH behaviour resumes on the first cycle after RST falls.

Verification
REQ-024 The bench SHALL cover these scenarios:
  - lw, OP=100011, MEM_READY=1 -> STATE 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
  - sw, OP=101011, MEM_READY held 0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, IorD=1, then STATE=0.
  - beq, OP=000100 -> STATE 0,1,8,0; PCWriteCond=1, ALUOp=01, PCSource=01 in state 8.
  - Illegal opcode, OP=111111 -> ILLEGAL=1 for exactly one cycle in DECODE, next STATE=0.
  - ADDI with ENABLE_ADDI=0 behaves as an illegal opcode; with ENABLE_ADDI=1 -> STATE 0,1,9,10,0.
  - RST=1 asserted in MEMRD with MEM_READY=0 -> STATE=0 next edge; outputs 0 while RST=1; after release, IRWrite=1 on the first cycle with MEM_READY=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/handshake inputs and control-word outputs of the multicycle controller
interface multicycle_control_if;
    logic [5:0] OP;
    logic       MEM_READY;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       ILLEGAL;
    logic [3:0] STATE;

    modport master (
        input  OP, MEM_READY,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, ILLEGAL, STATE
    );

    modport slave (
        output OP, MEM_READY,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, ILLEGAL, STATE
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style control FSM with memory wait states
module multicycle_control #(
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST,
    multicycle_control_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t state;
    state_t next_state;
    ctl_t   ctl;
    ctl_t   ctl_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        ctl        = '0;
        case (state)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = bus.MEM_READY;
                ctl.pc_write  = bus.MEM_READY;
                next_state    = bus.MEM_READY ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                ctl.alu_src_b = 2'b11;
                case (bus.OP)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYP:      next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI: begin
                        if (ENABLE_ADDI) begin
                            next_state = ADDIEX;
                        end else begin
                            ctl.illegal = 1'b1;
                        end
                    end
                    default:      ctl.illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                next_state    = (bus.OP == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.ior_d    = 1'b1;
                next_state   = bus.MEM_READY ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctl.reg_write = 1'b1;
                ctl.memto_reg = 1'b1;
            end
            MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.ior_d     = 1'b1;
                next_state    = bus.MEM_READY ? FETCH : MEMWR;
            end
            EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                next_state    = ALUWB;
            end
            ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = 2'b01;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'b01;
            end
            ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                next_state    = ADDIWB;
            end
            ADDIWB: begin
                ctl.reg_write = 1'b1;
            end
            JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'b10;
            end
            default: next_state = FETCH;
        endcase
    end

    // Reset masks every strobe, including the FETCH memory request
    assign ctl_out = RST ? '0 : ctl;

    assign bus.PCWrite     = ctl_out.pc_write;
    assign bus.PCWriteCond = ctl_out.pc_write_cond;
    assign bus.IorD        = ctl_out.ior_d;
    assign bus.MemRead     = ctl_out.mem_read;
    assign bus.MemWrite    = ctl_out.mem_write;
    assign bus.IRWrite     = ctl_out.ir_write;
    assign bus.MemtoReg    = ctl_out.memto_reg;
    assign bus.RegDst      = ctl_out.reg_dst;
    assign bus.RegWrite    = ctl_out.reg_write;
    assign bus.ALUSrcA     = ctl_out.alu_src_a;
    assign bus.ALUSrcB     = ctl_out.alu_src_b;
    assign bus.ALUOp       = ctl_out.alu_op;
    assign bus.PCSource    = ctl_out.pc_source;
    assign bus.ILLEGAL     = ctl_out.illegal;
    assign bus.STATE       = state;
endmodule
